vga_timing_master: RTL and testbench

Synthesizable VGA transmitter that generates negative-polarity HSYNC/VSYNC and blanked RGB for a parameterised raster, 640x480@60 by default with a 25.175 MHz PCLK. It fetches pixel colour from an upstream frame source through a fixed-latency request/return port. Its output pins are the same signals that VGA_SLAVE_MONITOR consumes, so benches connect the two back-to-back.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_delay_line.sv | 33 +++
 rtl/vga_timing_master.sv | 177 +++++++++++++++++
 tb/tb_vga_timing_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants, raster helpers and FSM state type for the VGA timing master.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int DEF_HORIZ_SYNC         = 96;
  localparam int DEF_HORIZ_BACK_PORCH   = 48;
  localparam int DEF_HORIZ_ACTIVE_WIDTH = 640;
  localparam int DEF_HORIZ_FRONT_PORCH  = 16;
  localparam int DEF_VERT_SYNC          = 2;
  localparam int DEF_VERT_BACK_PORCH    = 33;
  localparam int DEF_VERT_ACTIVE_HEIGHT = 480;
  localparam int DEF_VERT_FRONT_PORCH   = 10;
  localparam int DEF_COLOUR_DEPTH       = 8;
  localparam int DEF_PIX_LATENCY        = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

  function automatic int h_total(input int hs, input int hbp, input int haw, input int hfp);
    return hs + hbp + haw + hfp;
  endfunction

  function automatic int v_total(input int vs, input int vbp, input int vah, input int vfp);
    return vs + vbp + vah + vfp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register carrying raw hsync/vsync/de so they line up with
// the colour returned by the frame source. Resets to the inactive (sync-high) pattern.
module vga_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic hsync_i,
  input  logic vsync_i,
  input  logic de_i,
  output logic hsync_o,
  output logic vsync_o,
  output logic de_o
);

  localparam logic [2:0] RESET_VAL = 3'b110;

  logic [2:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
    end else begin
      stage_q[0] <= {hsync_i, vsync_i, de_i};
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign hsync_o = stage_q[DEPTH-1][2];
  assign vsync_o = stage_q[DEPTH-1][1];
  assign de_o    = stage_q[DEPTH-1][0];

endmodule

// File: rtl/vga_timing_master.sv
// VGA transmitter: lead raster counters issue pixel requests, and sync/DE are
// delayed to meet the returned colour so all display outputs lag the counters equally.
module vga_timing_master
  import vga_timing_pkg::*;
#(
  parameter int HORIZ_SYNC         = DEF_HORIZ_SYNC,
  parameter int HORIZ_BACK_PORCH   = DEF_HORIZ_BACK_PORCH,
  parameter int HORIZ_ACTIVE_WIDTH = DEF_HORIZ_ACTIVE_WIDTH,
  parameter int HORIZ_FRONT_PORCH  = DEF_HORIZ_FRONT_PORCH,
  parameter int VERT_SYNC          = DEF_VERT_SYNC,
  parameter int VERT_BACK_PORCH    = DEF_VERT_BACK_PORCH,
  parameter int VERT_ACTIVE_HEIGHT = DEF_VERT_ACTIVE_HEIGHT,
  parameter int VERT_FRONT_PORCH   = DEF_VERT_FRONT_PORCH,
  parameter int COLOUR_DEPTH       = DEF_COLOUR_DEPTH,
  parameter int PIX_LATENCY        = DEF_PIX_LATENCY
) (
  input  logic                                  PCLK,
  input  logic                                  RST_ASYNC_N,
  input  logic                                  EN,
  output logic                                  PIX_REQ_OUT,
  output logic [$clog2(HORIZ_ACTIVE_WIDTH)-1:0] PIX_X_OUT,
  output logic [$clog2(VERT_ACTIVE_HEIGHT)-1:0] PIX_Y_OUT,
  input  logic [COLOUR_DEPTH-1:0]               PIX_RED_IN,
  input  logic [COLOUR_DEPTH-1:0]               PIX_GREEN_IN,
  input  logic [COLOUR_DEPTH-1:0]               PIX_BLUE_IN,
  output logic                                  HSYNC_OUT,
  output logic                                  VSYNC_OUT,
  output logic                                  DE_OUT,
  output logic [COLOUR_DEPTH-1:0]               RED_OUT,
  output logic [COLOUR_DEPTH-1:0]               GREEN_OUT,
  output logic [COLOUR_DEPTH-1:0]               BLUE_OUT,
  output logic                                  FRAME_START_OUT,
  output logic [15:0]                           FRAME_CNT_OUT
);

  localparam int XW      = $clog2(HORIZ_ACTIVE_WIDTH);
  localparam int YW      = $clog2(VERT_ACTIVE_HEIGHT);
  localparam int H_TOTAL = h_total(HORIZ_SYNC, HORIZ_BACK_PORCH, HORIZ_ACTIVE_WIDTH, HORIZ_FRONT_PORCH);
  localparam int V_TOTAL = v_total(VERT_SYNC, VERT_BACK_PORCH, VERT_ACTIVE_HEIGHT, VERT_FRONT_PORCH);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(HORIZ_SYNC);
  localparam logic [HW-1:0] H_ACT_START = HW'(HORIZ_SYNC + HORIZ_BACK_PORCH);
  localparam logic [HW-1:0] H_ACT_LAST  = HW'(HORIZ_SYNC + HORIZ_BACK_PORCH + HORIZ_ACTIVE_WIDTH - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(VERT_SYNC);
  localparam logic [VW-1:0] V_ACT_START = VW'(VERT_SYNC + VERT_BACK_PORCH);
  localparam logic [VW-1:0] V_ACT_LAST  = VW'(VERT_SYNC + VERT_BACK_PORCH + VERT_ACTIVE_HEIGHT - 1);

  vga_state_e state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          req_q, req_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [COLOUR_DEPTH-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic          fstart_q, fstart_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic running, frame_end, active;
  logic hsync_raw, vsync_raw;
  logic dly_hsync, dly_vsync, dly_de;

  assign running   = (state_q != IDLE);
  assign frame_end = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  assign active    = running &&
                     (hcnt_q >= H_ACT_START) && (hcnt_q <= H_ACT_LAST) &&
                     (vcnt_q >= V_ACT_START) && (vcnt_q <= V_ACT_LAST);
  assign hsync_raw = !(running && (hcnt_q < H_SYNC_END));
  assign vsync_raw = !(running && (vcnt_q < V_SYNC_END));

  // EN is only honoured at frame boundaries so a frame is never cut short.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (EN) state_d = RUN;
      end
      RUN, DRAIN: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
        if (state_q == RUN && !EN) state_d = frame_end ? IDLE : DRAIN;
        if (state_q == DRAIN && frame_end) state_d = EN ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  vga_delay_line #(
    .DEPTH (PIX_LATENCY)
  ) u_delay (
    .clk_i   (PCLK),
    .rst_n_i (RST_ASYNC_N),
    .hsync_i (hsync_raw),
    .vsync_i (vsync_raw),
    .de_i    (active),
    .hsync_o (dly_hsync),
    .vsync_o (dly_vsync),
    .de_o    (dly_de)
  );

  // A frame begins where the delayed vsync falls; hsync falls on the same cycle.
  always_comb begin
    req_d    = active;
    x_d      = active ? XW'(hcnt_q - H_ACT_START) : '0;
    y_d      = active ? YW'(vcnt_q - V_ACT_START) : '0;
    hsync_d  = dly_hsync;
    vsync_d  = dly_vsync;
    de_d     = dly_de;
    red_d    = dly_de ? PIX_RED_IN   : '0;
    green_d  = dly_de ? PIX_GREEN_IN : '0;
    blue_d   = dly_de ? PIX_BLUE_IN  : '0;
    fstart_d = vsync_q && !dly_vsync;
    fcnt_d   = fcnt_q;
    if (fstart_d) fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge PCLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      req_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      de_q     <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      fstart_q <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      req_q    <= req_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      fstart_q <= fstart_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign PIX_REQ_OUT     = req_q;
  assign PIX_X_OUT       = x_q;
  assign PIX_Y_OUT       = y_q;
  assign HSYNC_OUT       = hsync_q;
  assign VSYNC_OUT       = vsync_q;
  assign DE_OUT          = de_q;
  assign RED_OUT         = red_q;
  assign GREEN_OUT       = green_q;
  assign BLUE_OUT        = blue_q;
  assign FRAME_START_OUT = fstart_q;
  assign FRAME_CNT_OUT   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_master.sv
// Bench for vga_timing_master on a tiny raster: a latency-accurate frame source
// feeds colours, and a scoreboard checks request order and blanked RGB/DE output.
module tb_vga_timing_master;

  localparam int HS = 2, HBP = 1, HAW = 4, HFP = 1;
  localparam int VS = 1, VBP = 1, VAH = 3, VFP = 1;
  localparam int LAT = 2, CD = 8;
  localparam int HT = HS + HBP + HAW + HFP;
  localparam int VT = VS + VBP + VAH + VFP;
  localparam int FRAME = HT * VT;
  localparam int PIXELS = HAW * VAH;

  logic pclk = 1'b0;
  logic rstN = 1'b0;
  logic en = 1'b0;
  logic pixReq;
  logic [1:0] pixX, pixY;
  logic [CD-1:0] pixRed = '0, pixGreen = '0, pixBlue = '0;
  logic hsync, vsync, de;
  logic [CD-1:0] red, green, blue;
  logic frameStart;
  logic [15:0] frameCnt;

  int checks = 0;
  int failures = 0;
  int reqIdx = 0;
  int popCount = 0;
  int expFrameCnt = 0;
  logic [23:0] sbQ [$];
  logic pipeValid [LAT];
  logic [1:0] pipeX [LAT];
  logic [1:0] pipeY [LAT];

  always #5 pclk = ~pclk;

  vga_timing_master #(
    .HORIZ_SYNC(HS), .HORIZ_BACK_PORCH(HBP), .HORIZ_ACTIVE_WIDTH(HAW), .HORIZ_FRONT_PORCH(HFP),
    .VERT_SYNC(VS), .VERT_BACK_PORCH(VBP), .VERT_ACTIVE_HEIGHT(VAH), .VERT_FRONT_PORCH(VFP),
    .COLOUR_DEPTH(CD), .PIX_LATENCY(LAT)
  ) dut (
    .PCLK(pclk), .RST_ASYNC_N(rstN), .EN(en),
    .PIX_REQ_OUT(pixReq), .PIX_X_OUT(pixX), .PIX_Y_OUT(pixY),
    .PIX_RED_IN(pixRed), .PIX_GREEN_IN(pixGreen), .PIX_BLUE_IN(pixBlue),
    .HSYNC_OUT(hsync), .VSYNC_OUT(vsync), .DE_OUT(de),
    .RED_OUT(red), .GREEN_OUT(green), .BLUE_OUT(blue),
    .FRAME_START_OUT(frameStart), .FRAME_CNT_OUT(frameCnt)
  );

  // Source model plus scoreboard: requests push the expected gradient colour,
  // DE pops it; outside valid slots the source drives junk that must be blanked.
  task automatic scoreboardMonitor();
    int expX, expY;
    logic [23:0] expRgb;
    forever begin
      @(negedge pclk);
      if (!rstN) begin
        sbQ.delete();
        reqIdx = 0;
        for (int k = 0; k < LAT; k++) begin
          pipeValid[k] = 1'b0; pipeX[k] = '0; pipeY[k] = '0;
        end
        pixRed = '0; pixGreen = '0; pixBlue = '0;
      end else begin
        if (pixReq === 1'b1) begin
          expX = reqIdx % HAW;
          expY = (reqIdx / HAW) % VAH;
          checks++;
          if (pixX !== 2'(expX) || pixY !== 2'(expY)) begin
            failures++;
            $display("[TB] FAIL req_coord idx=%0d: got (%0d,%0d) expected (%0d,%0d)", reqIdx, pixX, pixY, expX, expY);
          end
          sbQ.push_back({8'(expX), 8'(expY), 8'hA5});
          reqIdx++;
        end else begin
          checks++;
          if (pixX !== 2'd0 || pixY !== 2'd0) begin
            failures++;
            $display("[TB] FAIL idle_coord: got (%0d,%0d) expected (0,0)", pixX, pixY);
          end
        end
        if (de === 1'b1) begin
          checks++;
          if (sbQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL de_without_request: got DE=1 expected no pending pixel");
          end else begin
            expRgb = sbQ.pop_front();
            popCount++;
            if ({red, green, blue} !== expRgb) begin
              failures++;
              $display("[TB] FAIL rgb_data: got %06h expected %06h", {red, green, blue}, expRgb);
            end
          end
        end else begin
          checks++;
          if ({red, green, blue} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL rgb_blank: got %06h expected 000000", {red, green, blue});
          end
        end
        for (int k = LAT - 1; k > 0; k--) begin
          pipeValid[k] = pipeValid[k-1]; pipeX[k] = pipeX[k-1]; pipeY[k] = pipeY[k-1];
        end
        pipeValid[0] = pixReq; pipeX[0] = pixX; pipeY[0] = pixY;
        if (pipeValid[LAT-1]) begin
          pixRed = {6'd0, pipeX[LAT-1]}; pixGreen = {6'd0, pipeY[LAT-1]}; pixBlue = 8'hA5;
        end else begin
          pixRed = 8'($urandom) | 8'h01; pixGreen = 8'($urandom) | 8'h01; pixBlue = 8'($urandom) | 8'h01;
        end
      end
    end
  endtask

  task automatic waitFrameStart(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if (frameStart === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int idleBad = 0;
    rstN = 1'b0; en = 1'b0;
    repeat (3) @(negedge pclk);
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin failures++; $display("[TB] FAIL reset_sync: got hs=%0b vs=%0b expected 1 1", hsync, vsync); end
    checks++; if (de !== 1'b0 || {red, green, blue} !== 24'h0) begin failures++; $display("[TB] FAIL reset_video: got de=%0b rgb=%06h expected 0 000000", de, {red, green, blue}); end
    checks++; if (pixReq !== 1'b0 || pixX !== 2'd0 || pixY !== 2'd0) begin failures++; $display("[TB] FAIL reset_req: got req=%0b x=%0d y=%0d expected 0 0 0", pixReq, pixX, pixY); end
    checks++; if (frameStart !== 1'b0 || frameCnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_frame: got fs=%0b cnt=%0d expected 0 0", frameStart, frameCnt); end
    rstN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (hsync !== 1'b1 || vsync !== 1'b1 || pixReq !== 1'b0) idleBad++;
    end
    checks++; if (idleBad !== 0) begin failures++; $display("[TB] FAIL idle_hold: got %0d active cycles expected 0", idleBad); end
  endtask

  task automatic test_sync_timing();
    int k, falls = 0, lastFall = 0, spacingErr = 0, deOff = -1;
    int hsLow = 0, vsLow = 0, deCnt = 0, reqCnt = 0, fsCnt = 0;
    logic prevHs = 1'b1, prevDe = 1'b0;
    en = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(negedge pclk);
      if (hsync === 1'b0) break;
    end
    checks++; if (k !== LAT + 2) begin failures++; $display("[TB] FAIL start_latency: got %0d cycles expected %0d", k, LAT + 2); end
    checks++; if (vsync !== 1'b0 || frameStart !== 1'b1) begin failures++; $display("[TB] FAIL frame_start_align: got vs=%0b fs=%0b expected 0 1", vsync, frameStart); end
    expFrameCnt = 1;
    checks++; if (frameCnt !== 16'(expFrameCnt)) begin failures++; $display("[TB] FAIL first_frame_cnt: got %0d expected %0d", frameCnt, expFrameCnt); end
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge pclk);
      if (hsync === 1'b0 && prevHs === 1'b1) begin
        falls++;
        if (falls > 1 && (i - lastFall) != HT) spacingErr++;
        lastFall = i;
      end
      if (de === 1'b1 && prevDe === 1'b0 && deOff < 0) deOff = i - lastFall;
      hsLow += (hsync === 1'b0) ? 1 : 0;
      vsLow += (vsync === 1'b0) ? 1 : 0;
      deCnt += (de === 1'b1) ? 1 : 0;
      reqCnt += (pixReq === 1'b1) ? 1 : 0;
      fsCnt += (frameStart === 1'b1) ? 1 : 0;
      prevHs = hsync; prevDe = de;
    end
    checks++; if (hsLow !== HS * VT) begin failures++; $display("[TB] FAIL hsync_low: got %0d expected %0d", hsLow, HS * VT); end
    checks++; if (vsLow !== VS * HT) begin failures++; $display("[TB] FAIL vsync_low: got %0d expected %0d", vsLow, VS * HT); end
    checks++; if (falls !== VT || spacingErr !== 0) begin failures++; $display("[TB] FAIL hsync_period: got falls=%0d bad=%0d expected %0d 0", falls, spacingErr, VT); end
    checks++; if (deOff !== HS + HBP) begin failures++; $display("[TB] FAIL de_offset: got %0d expected %0d", deOff, HS + HBP); end
    checks++; if (deCnt !== PIXELS || reqCnt !== PIXELS) begin failures++; $display("[TB] FAIL pixel_count: got de=%0d req=%0d expected %0d", deCnt, reqCnt, PIXELS); end
    checks++; if (fsCnt !== 1) begin failures++; $display("[TB] FAIL frame_start_count: got %0d expected 1", fsCnt); end
  endtask

  task automatic test_gradient();
    bit found, allFound = 1'b1;
    int pop0;
    waitFrameStart(found);
    if (found) expFrameCnt++; else allFound = 1'b0;
    pop0 = popCount;
    repeat (3) begin
      waitFrameStart(found);
      if (found) expFrameCnt++; else allFound = 1'b0;
    end
    checks++; if (allFound !== 1'b1) begin failures++; $display("[TB] FAIL gradient_frames: got timeout expected frame starts"); end
    checks++; if (popCount - pop0 !== 3 * PIXELS) begin failures++; $display("[TB] FAIL gradient_pixels: got %0d expected %0d", popCount - pop0, 3 * PIXELS); end
    checks++; if (sbQ.size() !== 0) begin failures++; $display("[TB] FAIL gradient_pending: got %0d expected 0", sbQ.size()); end
    checks++; if (frameCnt !== 16'(expFrameCnt)) begin failures++; $display("[TB] FAIL gradient_frame_cnt: got %0d expected %0d", frameCnt, expFrameCnt); end
  endtask

  task automatic test_en_drop();
    bit found;
    int lowSeen = 0, fsSeen = 0;
    waitFrameStart(found);
    if (found) expFrameCnt++;
    checks++; if (found !== 1'b1) begin failures++; $display("[TB] FAIL drop_frame_wait: got timeout expected frame start"); end
    repeat (20) @(negedge pclk);
    en = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge pclk);
      if (i >= FRAME && (hsync !== 1'b1 || vsync !== 1'b1)) lowSeen++;
      if (frameStart === 1'b1) fsSeen++;
    end
    checks++; if (fsSeen !== 0) begin failures++; $display("[TB] FAIL drop_no_new_frame: got %0d starts expected 0", fsSeen); end
    checks++; if (lowSeen !== 0) begin failures++; $display("[TB] FAIL drop_sync_idle: got %0d low cycles expected 0", lowSeen); end
    checks++; if (reqIdx !== PIXELS * expFrameCnt) begin failures++; $display("[TB] FAIL drop_full_frame: got %0d requests expected %0d", reqIdx, PIXELS * expFrameCnt); end
    checks++; if (frameCnt !== 16'(expFrameCnt)) begin failures++; $display("[TB] FAIL drop_frame_cnt: got %0d expected %0d", frameCnt, expFrameCnt); end
    en = 1'b1;
    waitFrameStart(found);
    if (found) expFrameCnt++;
    checks++; if (found !== 1'b1 || hsync !== 1'b0 || vsync !== 1'b0) begin failures++; $display("[TB] FAIL restart_sync: got found=%0b hs=%0b vs=%0b expected 1 0 0", found, hsync, vsync); end
    checks++; if (frameCnt !== 16'(expFrameCnt)) begin failures++; $display("[TB] FAIL restart_frame_cnt: got %0d expected %0d", frameCnt, expFrameCnt); end
  endtask

  task automatic test_reset_midline();
    int k;
    repeat (12) @(negedge pclk);
    #2 rstN = 1'b0;
    #1;
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_sync: got hs=%0b vs=%0b de=%0b expected 1 1 0", hsync, vsync, de); end
    checks++; if ({red, green, blue} !== 24'h0 || pixReq !== 1'b0 || pixX !== 2'd0 || pixY !== 2'd0) begin failures++; $display("[TB] FAIL async_reset_data: got rgb=%06h req=%0b x=%0d y=%0d expected 0", {red, green, blue}, pixReq, pixX, pixY); end
    checks++; if (frameStart !== 1'b0 || frameCnt !== 16'd0) begin failures++; $display("[TB] FAIL async_reset_frame: got fs=%0b cnt=%0d expected 0 0", frameStart, frameCnt); end
    expFrameCnt = 0;
    @(negedge pclk);
    @(negedge pclk);
    rstN = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(negedge pclk);
      if (hsync === 1'b0) break;
    end
    checks++; if (k !== LAT + 2 || vsync !== 1'b0 || frameStart !== 1'b1) begin failures++; $display("[TB] FAIL restart_origin: got k=%0d vs=%0b fs=%0b expected %0d 0 1", k, vsync, frameStart, LAT + 2); end
    expFrameCnt = 1;
    checks++; if (frameCnt !== 16'(expFrameCnt)) begin failures++; $display("[TB] FAIL restart_cnt: got %0d expected %0d", frameCnt, expFrameCnt); end
    repeat (FRAME + 5) @(negedge pclk);
    checks++; if (reqIdx !== PIXELS) begin failures++; $display("[TB] FAIL restart_requests: got %0d expected %0d", reqIdx, PIXELS); end
  endtask

  initial begin
    $display("[TB] starting vga_timing_master bench");
    fork
      scoreboardMonitor();
    join_none
    test_reset();
    test_sync_timing();
    test_gradient();
    test_en_drop();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
